// File: rtl/risc_spm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_spm_pkg
// Description : Shared constants for the RISC SPM datapath and control unit:
//               word/opcode sizes, opcode values and bus select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_spm_pkg;

  // Datapath geometry
  localparam int c_word_size = 8;
  localparam int c_op_size   = 4;
  localparam int c_sel1_size = 3;
  localparam int c_sel2_size = 2;

  // Opcodes (upper op_size bits of the instruction word)
  localparam logic [c_op_size-1:0] c_op_nop = 4'd0;
  localparam logic [c_op_size-1:0] c_op_add = 4'd1;
  localparam logic [c_op_size-1:0] c_op_sub = 4'd2;
  localparam logic [c_op_size-1:0] c_op_and = 4'd3;
  localparam logic [c_op_size-1:0] c_op_not = 4'd4;
  localparam logic [c_op_size-1:0] c_op_rd  = 4'd5;
  localparam logic [c_op_size-1:0] c_op_wr  = 4'd6;
  localparam logic [c_op_size-1:0] c_op_br  = 4'd7;
  localparam logic [c_op_size-1:0] c_op_brz = 4'd8;
  localparam logic [c_op_size-1:0] c_op_eqz = 4'd9;
  localparam logic [c_op_size-1:0] c_op_ldr = 4'd10;

  // Bus_1 source selects; codes above c_sel1_pc drive zero
  localparam logic [c_sel1_size-1:0] c_sel1_r0 = 3'd0;
  localparam logic [c_sel1_size-1:0] c_sel1_r1 = 3'd1;
  localparam logic [c_sel1_size-1:0] c_sel1_r2 = 3'd2;
  localparam logic [c_sel1_size-1:0] c_sel1_r3 = 3'd3;
  localparam logic [c_sel1_size-1:0] c_sel1_pc = 3'd4;

  // Bus_2 source selects; c_sel2_zero drives zero
  localparam logic [c_sel2_size-1:0] c_sel2_alu  = 2'd0;
  localparam logic [c_sel2_size-1:0] c_sel2_bus1 = 2'd1;
  localparam logic [c_sel2_size-1:0] c_sel2_mem  = 2'd2;
  localparam logic [c_sel2_size-1:0] c_sel2_zero = 2'd3;

endpackage : risc_spm_pkg
`default_nettype wire

// File: rtl/alu_risc.sv
`default_nettype none
// ============================================================================
// Module      : alu_risc
// Description : Combinational ALU of the RISC SPM. Results wrap modulo
//               2^word_size; unsupported opcodes produce zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_risc
  import risc_spm_pkg::*;
#(
  parameter int word_size = c_word_size,
  parameter int op_size   = c_op_size
) (
  input  logic [word_size-1:0] a,
  input  logic [word_size-1:0] b,
  input  logic [op_size-1:0]   opcode,
  output logic [word_size-1:0] alu_out
);

  // Opcode decode; the default result keeps undefined opcodes at zero
  always_comb begin
    alu_out = '0;
    case (opcode)
      op_size'(c_op_add): alu_out = a + b;
      op_size'(c_op_sub): alu_out = b - a;
      op_size'(c_op_and): alu_out = a & b;
      op_size'(c_op_not): alu_out = ~b;
      op_size'(c_op_eqz): alu_out = a ^ b;
      default:            alu_out = '0;
    endcase
  end

endmodule : alu_risc
`default_nettype wire

// File: rtl/processing_unit.sv
`default_nettype none
// ============================================================================
// Module      : processing_unit
// Description : RISC SPM datapath: four general registers, PC, IR, address
//               register, ALU operand register Y and zero flag, joined by
//               two combinational buses around the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module processing_unit
  import risc_spm_pkg::*;
#(
  parameter int word_size = c_word_size,
  parameter int op_size   = c_op_size,
  parameter int Sel1_size = c_sel1_size,
  parameter int Sel2_size = c_sel2_size
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Load_R0,
  input  logic                 Load_R1,
  input  logic                 Load_R2,
  input  logic                 Load_R3,
  input  logic                 Load_PC,
  input  logic                 Inc_PC,
  input  logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  input  logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  input  logic                 Load_IR,
  input  logic                 Load_Add_R,
  input  logic                 Load_Reg_Y,
  input  logic                 Load_Reg_Z,
  input  logic [word_size-1:0] mem_word,
  output logic [word_size-1:0] instruction,
  output logic [word_size-1:0] address,
  output logic [word_size-1:0] Bus_1,
  output logic                 zero
);

  logic [word_size-1:0] r_gpr [4];
  logic [word_size-1:0] r_pc;
  logic [word_size-1:0] r_ir;
  logic [word_size-1:0] r_addr;
  logic [word_size-1:0] r_y;
  logic                 r_zero;

  logic [word_size-1:0] w_bus_1;
  logic [word_size-1:0] w_bus_2;
  logic [word_size-1:0] w_alu_out;
  logic [3:0]           w_load_gpr;

  assign w_load_gpr = {Load_R3, Load_R2, Load_R1, Load_R0};

  // Bus_1 source mux; unused select codes drive zero so no X escapes
  always_comb begin
    w_bus_1 = '0;
    case (Sel_Bus_1_Mux)
      Sel1_size'(c_sel1_r0): w_bus_1 = r_gpr[0];
      Sel1_size'(c_sel1_r1): w_bus_1 = r_gpr[1];
      Sel1_size'(c_sel1_r2): w_bus_1 = r_gpr[2];
      Sel1_size'(c_sel1_r3): w_bus_1 = r_gpr[3];
      Sel1_size'(c_sel1_pc): w_bus_1 = r_pc;
      default:               w_bus_1 = '0;
    endcase
  end

  // Bus_2 source mux feeding every register load
  always_comb begin
    w_bus_2 = '0;
    case (Sel_Bus_2_Mux)
      Sel2_size'(c_sel2_alu):  w_bus_2 = w_alu_out;
      Sel2_size'(c_sel2_bus1): w_bus_2 = w_bus_1;
      Sel2_size'(c_sel2_mem):  w_bus_2 = mem_word;
      default:                 w_bus_2 = '0;
    endcase
  end

  alu_risc #(
    .word_size (word_size),
    .op_size   (op_size)
  ) u_alu (
    .a       (r_y),
    .b       (w_bus_1),
    .opcode  (r_ir[word_size-1 -: op_size]),
    .alu_out (w_alu_out)
  );

  // Register file; non-blocking updates give read-before-write on Bus_1
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_gpr[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load_gpr[i]) r_gpr[i] <= w_bus_2;
      end
    end
  end

  // Program counter; an explicit load wins over increment
  always_ff @(posedge clk) begin
    if (!rst)         r_pc <= '0;
    else if (Load_PC) r_pc <= w_bus_2;
    else if (Inc_PC)  r_pc <= r_pc + word_size'(1);
  end

  // Instruction, address and ALU operand registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ir   <= '0;
      r_addr <= '0;
      r_y    <= '0;
    end else begin
      if (Load_IR)    r_ir   <= w_bus_2;
      if (Load_Add_R) r_addr <= w_bus_2;
      if (Load_Reg_Y) r_y    <= w_bus_2;
    end
  end

  // Zero flag captures whether the current ALU result is zero
  always_ff @(posedge clk) begin
    if (!rst)            r_zero <= 1'b0;
    else if (Load_Reg_Z) r_zero <= (w_alu_out == '0);
  end

  assign instruction = r_ir;
  assign address     = r_addr;
  assign Bus_1       = w_bus_1;
  assign zero        = r_zero;

endmodule : processing_unit
`default_nettype wire

// File: tb/tb_processing_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_processing_unit
// Description : Self-checking bench for processing_unit: directed scenarios
//               followed by random control traffic against a register-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processing_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic [7:0] mem_word;
  logic [7:0] instruction, address, Bus_1;
  logic       zero;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] m_r [4];
  logic [7:0] m_pc, m_ir, m_addr, m_y;
  logic       m_z;

  processing_unit dut (
    .clk           (clk),
    .rst           (rst),
    .Load_R0       (Load_R0),
    .Load_R1       (Load_R1),
    .Load_R2       (Load_R2),
    .Load_R3       (Load_R3),
    .Load_PC       (Load_PC),
    .Inc_PC        (Inc_PC),
    .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
    .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
    .Load_IR       (Load_IR),
    .Load_Add_R    (Load_Add_R),
    .Load_Reg_Y    (Load_Reg_Y),
    .Load_Reg_Z    (Load_Reg_Z),
    .mem_word      (mem_word),
    .instruction   (instruction),
    .address       (address),
    .Bus_1         (Bus_1),
    .zero          (zero)
  );

  always #50 clk = ~clk;

  function automatic logic [7:0] m_bus1(input logic [2:0] s);
    if (s < 3'd4) return m_r[s[1:0]];
    if (s == 3'd4) return m_pc;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return b - a;
      4'd3:    return a & b;
      4'd4:    return ~b;
      4'd9:    return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {Load_R0, Load_R1, Load_R2, Load_R3} = 4'b0;
    {Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z} = 6'b0;
    Sel_Bus_1_Mux = 3'd0;
    Sel_Bus_2_Mux = 2'd0;
    mem_word      = 8'h00;
  endtask

  // One clock: check Bus_1 before the edge, advance the model, check outputs
  task automatic tick();
    logic [7:0] b1, b2, alu;
    logic [3:0] ld_r;
    #1;
    b1  = m_bus1(Sel_Bus_1_Mux);
    alu = m_alu(m_ir[7:4], m_y, b1);
    case (Sel_Bus_2_Mux)
      2'd0:    b2 = alu;
      2'd1:    b2 = b1;
      2'd2:    b2 = mem_word;
      default: b2 = 8'h00;
    endcase
    chk("bus1_pre_edge", Bus_1, b1);
    ld_r = {Load_R3, Load_R2, Load_R1, Load_R0};
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00; m_y = 8'h00; m_z = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (ld_r[i]) m_r[i] = b2;
      if (Load_PC)     m_pc = b2;
      else if (Inc_PC) m_pc = m_pc + 8'h01;
      if (Load_IR)     m_ir = b2;
      if (Load_Add_R)  m_addr = b2;
      if (Load_Reg_Y)  m_y = b2;
      if (Load_Reg_Z)  m_z = (alu == 8'h00);
    end
    #1;
    chk("instruction", instruction, m_ir);
    chk("address", address, m_addr);
    chk("zero", {7'b0, zero}, {7'b0, m_z});
  endtask

  // Observe a register through Bus_1 against a fixed expected value
  task automatic read_reg(input string tag, input logic [2:0] s, input logic [7:0] exp);
    idle();
    Sel_Bus_1_Mux = s;
    #1;
    chk(tag, Bus_1, exp);
  endtask

  task automatic check_all();
    idle();
    for (int s = 0; s < 8; s++) begin
      Sel_Bus_1_Mux = 3'(s);
      #1;
      chk("bus1_sweep", Bus_1, m_bus1(3'(s)));
    end
  endtask

  task automatic load_mem(input logic [3:0] regs, input logic [7:0] v);
    idle();
    {Load_R3, Load_R2, Load_R1, Load_R0} = regs;
    Sel_Bus_2_Mux = 2'd2;
    mem_word      = v;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00; m_y = 8'h00; m_z = 1'b0;
    idle();
    rst = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b1;

    // Preload everything with A5 (IR is 0 so ALU result is 0 and zero sets)
    idle();
    {Load_R0, Load_R1, Load_R2, Load_R3} = 4'b1111;
    {Load_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z} = 5'b11111;
    Sel_Bus_2_Mux = 2'd2; mem_word = 8'hA5;
    tick();
    chk("preload_ir", instruction, 8'hA5);
    chk("preload_zero", {7'b0, zero}, 8'h01);
    read_reg("preload_r3", 3'd3, 8'hA5);
    read_reg("preload_pc", 3'd4, 8'hA5);

    // Reset clears all state
    idle(); rst = 1'b0; tick(); rst = 1'b1;
    chk("rst_ir", instruction, 8'h00);
    chk("rst_addr", address, 8'h00);
    chk("rst_zero", {7'b0, zero}, 8'h00);
    for (int s = 0; s < 5; s++) read_reg("rst_reg", 3'(s), 8'h00);

    // Reset overrides a simultaneous load
    load_mem(4'b0100, 8'h33);
    idle(); rst = 1'b0; Load_R2 = 1'b1; Sel_Bus_2_Mux = 2'd2; mem_word = 8'h44;
    tick(); rst = 1'b1;
    read_reg("rst_mid_r2", 3'd2, 8'h00);

    // ADD: R2 = R1 + R2
    load_mem(4'b0010, 8'h05);
    load_mem(4'b0100, 8'h0C);
    idle(); Sel_Bus_1_Mux = 3'd1; Sel_Bus_2_Mux = 2'd1; Load_Reg_Y = 1'b1; tick();
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h10; Load_IR = 1'b1; tick();
    idle(); Sel_Bus_1_Mux = 3'd2; Load_R2 = 1'b1; Load_Reg_Z = 1'b1; tick();
    read_reg("add_r2", 3'd2, 8'h11);
    chk("add_zero", {7'b0, zero}, 8'h00);

    // SUB to zero, then SUB with borrow wrap
    load_mem(4'b0001, 8'h07);
    idle(); Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd1; Load_Reg_Y = 1'b1; tick();
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h20; Load_IR = 1'b1; tick();
    idle(); Sel_Bus_1_Mux = 3'd0; Load_Reg_Z = 1'b1; tick();
    chk("sub_zero_flag", {7'b0, zero}, 8'h01);
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h01; Load_Reg_Y = 1'b1; tick();
    idle(); Sel_Bus_2_Mux = 2'd3; Load_R3 = 1'b1; tick();
    idle(); Sel_Bus_1_Mux = 3'd3; Load_R0 = 1'b1; Load_Reg_Z = 1'b1; tick();
    read_reg("sub_wrap_r0", 3'd0, 8'hFF);
    chk("sub_wrap_zero", {7'b0, zero}, 8'h00);

    // PC wrap and load-over-increment
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'hFF; Load_PC = 1'b1; tick();
    idle(); Inc_PC = 1'b1; tick();
    read_reg("pc_wrap", 3'd4, 8'h00);
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h3C; Load_PC = 1'b1; Inc_PC = 1'b1; tick();
    read_reg("pc_load_prio", 3'd4, 8'h3C);

    // Fetch: address from PC, then IR from memory with PC increment
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h10; Load_PC = 1'b1; tick();
    idle(); Sel_Bus_1_Mux = 3'd4; Sel_Bus_2_Mux = 2'd1; Load_Add_R = 1'b1; tick();
    chk("fetch_addr", address, 8'h10);
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h96; Load_IR = 1'b1; Inc_PC = 1'b1; tick();
    chk("fetch_ir", instruction, 8'h96);
    read_reg("fetch_pc", 3'd4, 8'h11);

    // Out-of-range selects and EQZ
    read_reg("sel1_6", 3'd6, 8'h00);
    idle(); Sel_Bus_2_Mux = 2'd3; Load_R1 = 1'b1; tick();
    read_reg("sel2_3_r1", 3'd1, 8'h00);
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h5A; Load_Reg_Y = 1'b1; Load_R3 = 1'b1; tick();
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h90; Load_IR = 1'b1; tick();
    idle(); Sel_Bus_1_Mux = 3'd3; Load_Reg_Z = 1'b1; tick();
    chk("eqz_zero", {7'b0, zero}, 8'h01);

    // Read-before-write: R1 = Y + R1 using R1 as the source
    load_mem(4'b0010, 8'h21);
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h01; Load_Reg_Y = 1'b1; tick();
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h10; Load_IR = 1'b1; tick();
    idle(); Sel_Bus_1_Mux = 3'd1; Load_R1 = 1'b1; tick();
    read_reg("rbw_r1", 3'd1, 8'h22);

    // Several loads share one Bus_2 value
    idle(); Sel_Bus_2_Mux = 2'd2; mem_word = 8'h77;
    Load_R0 = 1'b1; Load_R3 = 1'b1; Load_Add_R = 1'b1; Load_PC = 1'b1; tick();
    read_reg("multi_r0", 3'd0, 8'h77);
    read_reg("multi_r3", 3'd3, 8'h77);
    chk("multi_addr", address, 8'h77);
    check_all();

    // Random control traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      rst           = ($urandom_range(0, 24) != 0);
      {Load_R0, Load_R1, Load_R2, Load_R3} = 4'($urandom);
      Load_PC       = ($urandom_range(0, 3) == 0);
      Inc_PC        = $urandom_range(0, 1) == 1;
      Load_IR       = ($urandom_range(0, 3) == 0);
      Load_Add_R    = $urandom_range(0, 1) == 1;
      Load_Reg_Y    = $urandom_range(0, 1) == 1;
      Load_Reg_Z    = $urandom_range(0, 1) == 1;
      Sel_Bus_1_Mux = 3'($urandom);
      Sel_Bus_2_Mux = 2'($urandom);
      mem_word      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
      if (n % 4 == 0) check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_processing_unit
`default_nettype wire

// File: doc/processing_unit.md
PROCESSING_UNIT -- requirements
Module: processing_unit

Interface
REQ-001 SHALL have parameters: word_size, default 8, datapath width; op_size, default 4, opcode field width; Sel1_size, default 3, Bus_1 select width; Sel2_size, default 2, Bus_2 select width.
REQ-002 SHALL have ports (one per line, name direction width meaning):
  clk  input  1  single clock, all state updates on rising edge
  rst  input  1  reset, synchronous, active-low
  Load_R0, Load_R1, Load_R2, Load_R3  input  1 each  load Rn from Bus_2
  Load_PC  input  1  load PC from Bus_2
  Inc_PC  input  1  increment PC
  Sel_Bus_1_Mux  input  Sel1_size  Bus_1 source select
  Sel_Bus_2_Mux  input  Sel2_size  Bus_2 source select
  Load_IR  input  1  load IR from Bus_2
  Load_Add_R  input  1  load Addr_R from Bus_2
  Load_Reg_Y  input  1  load Y from Bus_2
  Load_Reg_Z  input  1  load zero flag from ALU result
  mem_word  input  word_size  memory read data
  instruction  output  word_size  IR contents
  address  output  word_size  Addr_R contents (memory address)
  Bus_1  output  word_size  Bus_1 value (memory write data)
  zero  output  1  zero flag register

Function
REQ-003 Bus_1 SHALL be combinational: select 0..3 -> R0..R3, 4 -> PC, 5..7 -> 0.
REQ-004 Bus_2 SHALL be combinational: select 0 -> alu_out, 1 -> Bus_1, 2 -> mem_word, 3 -> 0.
REQ-005 ALU operands: a = Y, b = Bus_1; opcode = instruction[word_size-1 -: op_size].
REQ-006 ALU ops: ADD(1) a+b; SUB(2) b-a; AND(3) a&b; NOT(4) ~b; EQZ(9) a^b; all other opcodes -> 0.
REQ-007 Arithmetic SHALL be modulo 2^word_size; carry/borrow discarded, no overflow flag.
REQ-008 On Load_Reg_Z, zero SHALL register (alu_out == 0) at next edge; otherwise hold.
REQ-009 R0..R3, IR, Addr_R, Y SHALL each load Bus_2 at next edge when own load is high, else hold.
REQ-010 PC: Load_PC -> Bus_2; else Inc_PC -> PC+1 (8'hFF wraps to 8'h00); else hold.
REQ-011 Load_PC and Inc_PC both high SHALL load Bus_2 (no increment).
REQ-012 Register selected on Bus_1 and loaded same cycle SHALL read old value, store new (read-before-write).
REQ-013 Multiple loads same cycle SHALL all take the same Bus_2 value.
REQ-014 Bus_1, Bus_2, alu_out SHALL have zero-cycle latency; register outputs update one cycle after load.
REQ-015 No X SHALL propagate from undefined selects; out-of-range selects give 0 per REQ-003/004.

Reset
REQ-016 When rst==0 at rising clk edge: R0..R3, PC, IR, Addr_R, Y SHALL be 0, zero SHALL be 0.
REQ-017 Reset SHALL take priority over every load/increment, including mid-instruction.
REQ-018 No state SHALL change asynchronously on rst.

Structure
REQ-019 Shared package risc_spm_pkg SHALL hold opcode constants (NOP..LDR), Bus_1/Bus_2 select codes, and word/op sizes, shared with the control unit.
REQ-020 ALU SHALL be a separate combinational sub-module alu_risc (ports a, b, opcode, alu_out).
REQ-021 Registers SHALL be in this module; no latches.

Verification
REQ-022 Reset: preload all regs 8'hA5, hold rst=0 one edge -> all regs and zero = 0; mid-load rst=0 with Load_R2 -> R2 = 0.
REQ-023 ADD: R1=8'h05, R2=8'h0C; Sel1=1, Load_Reg_Y; then IR opcode 1, Sel1=2, Sel2=0, Load_R2, Load_Reg_Z -> R2=8'h11, zero=0.
REQ-024 SUB wrap/zero: Y=8'h07, Bus_1=8'h07 opcode 2 -> result 0, zero=1; Y=8'h01, Bus_1=0 -> 8'hFF, zero=0.
REQ-025 PC: PC=8'hFF, Inc_PC -> 8'h00; Load_PC+Inc_PC with Bus_2=mem_word=8'h3C -> PC=8'h3C.
REQ-026 Fetch: PC=8'h10, Sel1=4, Sel2=1, Load_Add_R -> address=8'h10; mem_word=8'h96, Sel2=2, Load_IR, Inc_PC -> instruction=8'h96, PC=8'h11.
REQ-027 Selects/EQZ: Sel1=6 -> Bus_1=0; Sel2=3 -> Bus_2=0; EQZ with Y=Bus_1=8'h5A -> zero=1.
